// File: rtl/noc_link_pkg.sv
// Shared types and constants for the router-to-router credit link.
package noc_link_pkg;

  localparam int FLIT_WIDTH     = 128;
  localparam int DEST_WIDTH     = 6;
  localparam int PERF_CNT_WIDTH = 32;

  typedef enum logic {
    LINK_IDLE,
    LINK_BODY
  } link_state_e;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
    logic                  send;
  } flit_t;

endpackage

// File: rtl/noc_link_monitor.sv
// One channel's credit counter, packet framing FSM, sticky errors and perf counters.
// Perf counters are built only when NOC_LINK_PERF_EN is defined.
//
//   state     | meaning
//   LINK_IDLE | between packets; next flit is a header
//   LINK_BODY | header seen; flits must carry the latched dest until the tail
module noc_link_monitor
  import noc_link_pkg::link_state_e;
  import noc_link_pkg::LINK_IDLE;
  import noc_link_pkg::LINK_BODY;
  import noc_link_pkg::PERF_CNT_WIDTH;
#(
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                      clk_noc,
  input  logic                      rst_n,
  input  logic                      send,
  input  logic                      is_tail,
  input  logic [DEST_WIDTH-1:0]     dest,
  input  logic                      credit,
  input  logic                      err_clear,
  output logic [CNT_WIDTH-1:0]      credits_avail,
  output logic                      err_underflow,
  output logic                      err_overflow,
  output logic                      err_dest,
  output logic [PERF_CNT_WIDTH-1:0] perf_flits,
  output logic [PERF_CNT_WIDTH-1:0] perf_pkts
);

  localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  underflow, overflow, dest_err;
  link_state_e           state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  uf_q, of_q, de_q;

  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    overflow  = 1'b0;
    if (send && !credit) begin
      if (count_q == '0) underflow = 1'b1;
      else               count_d   = count_q - CNT_WIDTH'(1);
    end else if (credit && !send) begin
      if (count_q == DEPTH) overflow = 1'b1;
      else                  count_d  = count_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    dest_err = 1'b0;
    case (state_q)
      LINK_IDLE: begin
        if (send && !is_tail) begin
          state_d = LINK_BODY;
          dest_d  = dest;
        end
      end
      LINK_BODY: begin
        if (send) begin
          dest_err = (dest != dest_q);
          if (is_tail) state_d = LINK_IDLE;
        end
      end
      default: state_d = LINK_IDLE;
    endcase
  end

  // A fresh error outranks a coincident clear.
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      count_q <= DEPTH;
      state_q <= LINK_IDLE;
      dest_q  <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      dest_q  <= dest_d;
      uf_q    <= (uf_q & ~err_clear) | underflow;
      of_q    <= (of_q & ~err_clear) | overflow;
      de_q    <= (de_q & ~err_clear) | dest_err;
    end
  end

  assign credits_avail = count_q;
  assign err_underflow = uf_q;
  assign err_overflow  = of_q;
  assign err_dest      = de_q;

`ifdef NOC_LINK_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] flits_q, pkts_q;
  logic                      pkt_end;

  assign pkt_end = send & is_tail;

  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      flits_q <= '0;
      pkts_q  <= '0;
    end else if (err_clear) begin
      flits_q <= send    ? PERF_CNT_WIDTH'(1) : '0;
      pkts_q  <= pkt_end ? PERF_CNT_WIDTH'(1) : '0;
    end else begin
      if (send && flits_q != '1)   flits_q <= flits_q + PERF_CNT_WIDTH'(1);
      if (pkt_end && pkts_q != '1) pkts_q  <= pkts_q + PERF_CNT_WIDTH'(1);
    end
  end

  assign perf_flits = flits_q;
  assign perf_pkts  = pkts_q;
`else
  assign perf_flits = '0;
  assign perf_pkts  = '0;
`endif

endmodule

// File: rtl/noc_credit_link.sv
// Pipelined multi-channel credit link with per-channel protocol monitors.
// Define NOC_LINK_PERF_EN to build the per-channel flit/packet counters.
module noc_credit_link #(
  parameter int NUM_CHANNELS      = 4,
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 6,
  parameter int NUM_PIPELINE      = 1,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                                     clk_noc,
  input  logic                                     rst_n,
  input  logic [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0]  data_in,
  input  logic [0:NUM_CHANNELS-1][DEST_WIDTH-1:0]  dest_in,
  input  logic [0:NUM_CHANNELS-1]                  is_tail_in,
  input  logic [0:NUM_CHANNELS-1]                  send_in,
  output logic [0:NUM_CHANNELS-1]                  credit_out,
  output logic [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0]  data_out,
  output logic [0:NUM_CHANNELS-1][DEST_WIDTH-1:0]  dest_out,
  output logic [0:NUM_CHANNELS-1]                  is_tail_out,
  output logic [0:NUM_CHANNELS-1]                  send_out,
  input  logic [0:NUM_CHANNELS-1]                  credit_in,
  output logic [0:NUM_CHANNELS-1][CNT_WIDTH-1:0]   credits_avail,
  output logic [0:NUM_CHANNELS-1]                  err_underflow,
  output logic [0:NUM_CHANNELS-1]                  err_overflow,
  output logic [0:NUM_CHANNELS-1]                  err_dest,
  input  logic                                     err_clear,
  output logic [0:NUM_CHANNELS-1][noc_link_pkg::PERF_CNT_WIDTH-1:0] perf_flits,
  output logic [0:NUM_CHANNELS-1][noc_link_pkg::PERF_CNT_WIDTH-1:0] perf_pkts
);

  if (NUM_PIPELINE == 0) begin : g_bypass
    assign data_out    = data_in;
    assign dest_out    = dest_in;
    assign is_tail_out = is_tail_in;
    assign send_out    = send_in;
    assign credit_out  = credit_in;
  end else begin : g_pipe
    logic [NUM_PIPELINE-1:0][0:NUM_CHANNELS-1][FLIT_WIDTH-1:0] data_q;
    logic [NUM_PIPELINE-1:0][0:NUM_CHANNELS-1][DEST_WIDTH-1:0] dest_q;
    logic [NUM_PIPELINE-1:0][0:NUM_CHANNELS-1]                 tail_q;
    logic [NUM_PIPELINE-1:0][0:NUM_CHANNELS-1]                 send_q;
    logic [NUM_PIPELINE-1:0][0:NUM_CHANNELS-1]                 credit_q;

    // Reset flushes every stage so in-flight flits and credits are dropped.
    always_ff @(posedge clk_noc) begin
      if (!rst_n) begin
        data_q   <= '0;
        dest_q   <= '0;
        tail_q   <= '0;
        send_q   <= '0;
        credit_q <= '0;
      end else begin
        data_q[0]   <= data_in;
        dest_q[0]   <= dest_in;
        tail_q[0]   <= is_tail_in;
        send_q[0]   <= send_in;
        credit_q[0] <= credit_in;
        for (int s = 1; s < NUM_PIPELINE; s++) begin
          data_q[s]   <= data_q[s-1];
          dest_q[s]   <= dest_q[s-1];
          tail_q[s]   <= tail_q[s-1];
          send_q[s]   <= send_q[s-1];
          credit_q[s] <= credit_q[s-1];
        end
      end
    end

    assign data_out    = data_q[NUM_PIPELINE-1];
    assign dest_out    = dest_q[NUM_PIPELINE-1];
    assign is_tail_out = tail_q[NUM_PIPELINE-1];
    assign send_out    = send_q[NUM_PIPELINE-1];
    assign credit_out  = credit_q[NUM_PIPELINE-1];
  end

  // Monitors watch upstream sends against the credits actually handed back.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_mon
    noc_link_monitor #(
      .DEST_WIDTH        (DEST_WIDTH),
      .FLIT_BUFFER_DEPTH (FLIT_BUFFER_DEPTH),
      .CNT_WIDTH         (CNT_WIDTH)
    ) u_mon (
      .clk_noc       (clk_noc),
      .rst_n         (rst_n),
      .send          (send_in[c]),
      .is_tail       (is_tail_in[c]),
      .dest          (dest_in[c]),
      .credit        (credit_out[c]),
      .err_clear     (err_clear),
      .credits_avail (credits_avail[c]),
      .err_underflow (err_underflow[c]),
      .err_overflow  (err_overflow[c]),
      .err_dest      (err_dest[c]),
      .perf_flits    (perf_flits[c]),
      .perf_pkts     (perf_pkts[c])
    );
  end

endmodule

// File: tb/tb_noc_credit_link.sv
// Directed bench for noc_credit_link: 3-stage pipeline, 4-deep downstream buffer.
module tb_noc_credit_link;

  localparam int NC = 4;
  localparam int FW = 32;
  localparam int DW = 6;
  localparam int NP = 3;
  localparam int DEPTH = 4;
  localparam int CW = 3;
`ifdef NOC_LINK_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                  clk_noc = 1'b0;
  logic                  rst_n;
  logic [0:NC-1][FW-1:0] data_in, data_out;
  logic [0:NC-1][DW-1:0] dest_in, dest_out;
  logic [0:NC-1]         is_tail_in, is_tail_out, send_in, send_out;
  logic [0:NC-1]         credit_in, credit_out;
  logic [0:NC-1][CW-1:0] credits_avail;
  logic [0:NC-1]         err_underflow, err_overflow, err_dest;
  logic                  err_clear;
  logic [0:NC-1][31:0]   perf_flits, perf_pkts;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_noc = ~clk_noc;

  noc_credit_link #(
    .NUM_CHANNELS      (NC),
    .FLIT_WIDTH        (FW),
    .DEST_WIDTH        (DW),
    .NUM_PIPELINE      (NP),
    .FLIT_BUFFER_DEPTH (DEPTH)
  ) dut (
    .clk_noc       (clk_noc),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .dest_in       (dest_in),
    .is_tail_in    (is_tail_in),
    .send_in       (send_in),
    .credit_out    (credit_out),
    .data_out      (data_out),
    .dest_out      (dest_out),
    .is_tail_out   (is_tail_out),
    .send_out      (send_out),
    .credit_in     (credit_in),
    .credits_avail (credits_avail),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow),
    .err_dest      (err_dest),
    .err_clear     (err_clear),
    .perf_flits    (perf_flits),
    .perf_pkts     (perf_pkts)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_noc);
      #1;
    end
  endtask

  task automatic flit(input int ch, input logic [DW-1:0] d, input logic tail);
    send_in[ch]    = 1'b1;
    dest_in[ch]    = d;
    is_tail_in[ch] = tail;
    tick();
    send_in[ch]    = 1'b0;
    is_tail_in[ch] = 1'b0;
  endtask

  task automatic credits(input int ch, input int n);
    credit_in[ch] = 1'b1;
    tick(n);
    credit_in[ch] = 1'b0;
    tick(NP + 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    data_in    = '0;
    dest_in    = '0;
    is_tail_in = '0;
    send_in    = '0;
    credit_in  = '0;
    err_clear  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick();

    chk("rst_send_out", 64'(send_out), 64'd0);
    chk("rst_credit_out", 64'(credit_out), 64'd0);
    chk("rst_credits_ch0", 64'(credits_avail[0]), 64'(DEPTH));
    chk("rst_errs", 64'({err_underflow, err_overflow, err_dest}), 64'd0);
    chk("rst_perf", 64'(perf_flits[0]), 64'd0);

    // 3-flit packet on ch1, dest 5; flit driven in cycle c shows at output in cycle c+NP
    for (int c = 0; c < 7; c++) begin
      int j;
      if (c < 3) begin
        send_in[1]    = 1'b1;
        data_in[1]    = 32'hA000_0000 + 32'(c);
        dest_in[1]    = 6'h05;
        is_tail_in[1] = (c == 2);
      end else begin
        send_in[1]    = 1'b0;
        is_tail_in[1] = 1'b0;
        data_in[1]    = '0;
      end
      tick();
      j = c - (NP - 1);
      if (j >= 0 && j < 3) begin
        chk("fwd_send", 64'(send_out[1]), 64'd1);
        chk("fwd_data", 64'(data_out[1]), 64'(32'hA000_0000 + 32'(j)));
        chk("fwd_dest", 64'(dest_out[1]), 64'h05);
        chk("fwd_tail", 64'(is_tail_out[1]), 64'(j == 2));
      end else begin
        chk("fwd_idle", 64'(send_out), 64'd0);
      end
    end
    chk("fwd_credits", 64'(credits_avail[1]), 64'd1);
    chk("fwd_no_err", 64'({err_underflow[1], err_overflow[1], err_dest[1]}), 64'd0);
    credits(1, 3);
    chk("fwd_credits_back", 64'(credits_avail[1]), 64'(DEPTH));

    // Underflow on ch2
    for (int i = 0; i < 4; i++) flit(2, 6'h01, 1'b1);
    chk("uf_count0", 64'(credits_avail[2]), 64'd0);
    chk("uf_not_yet", 64'(err_underflow[2]), 64'd0);
    flit(2, 6'h01, 1'b1);
    chk("uf_flag", 64'(err_underflow[2]), 64'd1);
    chk("uf_hold0", 64'(credits_avail[2]), 64'd0);
    credits(2, 2);
    chk("cr_count2", 64'(credits_avail[2]), 64'd2);

    // Credit returning in the same cycle as a send
    credit_in[2] = 1'b1;
    tick();
    credit_in[2] = 1'b0;
    tick(NP - 1);
    chk("cr_latency", 64'(credit_out[2]), 64'd1);
    flit(2, 6'h01, 1'b1);
    chk("both_hold2", 64'(credits_avail[2]), 64'd2);
    chk("both_credit_gone", 64'(credit_out[2]), 64'd0);

    // Overflow: credits 2 -> 4, then one more
    credits(2, 3);
    chk("of_count4", 64'(credits_avail[2]), 64'(DEPTH));
    chk("of_flag", 64'(err_overflow[2]), 64'd1);
    chk("of_uf_sticky", 64'(err_underflow[2]), 64'd1);

    // Dest mismatch on ch3
    flit(3, 6'h05, 1'b0);
    chk("de_header_ok", 64'(err_dest[3]), 64'd0);
    flit(3, 6'h03, 1'b0);
    chk("de_flag", 64'(err_dest[3]), 64'd1);
    flit(3, 6'h05, 1'b1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clr_dest", 64'(err_dest[3]), 64'd0);
    chk("clr_uf", 64'(err_underflow[2]), 64'd0);
    chk("clr_of", 64'(err_overflow[2]), 64'd0);
    credits(3, 3);
    chk("de_credits", 64'(credits_avail[3]), 64'(DEPTH));

    // Violation coincident with err_clear: flag must stay set
    flit(3, 6'h05, 1'b0);
    err_clear = 1'b1;
    flit(3, 6'h03, 1'b1);
    err_clear = 1'b0;
    chk("clr_vs_err", 64'(err_dest[3]), 64'd1);
    chk("clr_vs_perf_flits", 64'(perf_flits[3]), PERF ? 64'd1 : 64'd0);
    chk("clr_vs_perf_pkts", 64'(perf_pkts[3]), PERF ? 64'd1 : 64'd0);
    chk("clr_no_uf3", 64'(err_underflow[3]), 64'd0);

    // 10 packets of 3 flits on ch0, credits returned at line rate
    for (int i = 0; i < 30; i++) begin
      send_in[0]    = 1'b1;
      dest_in[0]    = 6'h2A;
      is_tail_in[0] = (i % 3 == 2);
      credit_in[0]  = 1'b1;
      tick();
      if (i == 10) chk("perf_steady_credits", 64'(credits_avail[0]), 64'd1);
    end
    send_in[0]    = 1'b0;
    is_tail_in[0] = 1'b0;
    credit_in[0]  = 1'b0;
    tick(NP + 1);
    chk("perf_flits", 64'(perf_flits[0]), PERF ? 64'd30 : 64'd0);
    chk("perf_pkts", 64'(perf_pkts[0]), PERF ? 64'd10 : 64'd0);
    chk("perf_credits", 64'(credits_avail[0]), 64'(DEPTH));
    chk("perf_no_err", 64'({err_underflow[0], err_overflow[0], err_dest[0]}), 64'd0);

    // Reset in the middle of a packet with flits and credits in flight
    send_in[1]   = 1'b1;
    dest_in[1]   = 6'h05;
    credit_in[1] = 1'b1;
    tick(2);
    rst_n      = 1'b0;
    send_in    = '0;
    credit_in  = '0;
    is_tail_in = '0;
    tick();
    rst_n = 1'b1;
    chk("rr_send_out", 64'(send_out), 64'd0);
    chk("rr_credit_out", 64'(credit_out), 64'd0);
    chk("rr_credits", 64'(credits_avail[1]), 64'(DEPTH));
    chk("rr_errs", 64'({err_underflow, err_overflow, err_dest}), 64'd0);
    chk("rr_perf", 64'(perf_flits[0]), 64'd0);
    flit(1, 6'h03, 1'b0);
    flit(1, 6'h03, 1'b1);
    chk("rr_fsm_idle", 64'(err_dest[1]), 64'd0);
    chk("rr_after_credits", 64'(credits_avail[1]), 64'(DEPTH - 2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_credit_link.md
Name: noc_credit_link

Overview:
- Parametrised multi-channel router-to-router link: inserts NUM_PIPELINE register stages on the forward flit path (data/dest/is_tail/send) and on the backward credit path, per channel.
- Each channel carries a credit/protocol monitor. The monitor tracks upstream credits and packet framing, and raises sticky error flags.
- Instantiated between adjacent router ports (one instance per router side, NUM_CHANNELS = ports or VCs per side). It replaces bare wire links.

Parameters:
- NUM_CHANNELS, 4, independent links bundled in this instance
- FLIT_WIDTH, 128, flit data width
- DEST_WIDTH, 6, destination field width (TDEST_WIDTH + TID_WIDTH)
- NUM_PIPELINE, 1, register stages each direction; 0 = combinational pass-through
- FLIT_BUFFER_DEPTH, 1, downstream input buffer depth; initial credit count
- CNT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived)

Ports:
- clk_noc  in  1  link clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- data_in  in  [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0]  upstream flit data
- dest_in  in  [0:NUM_CHANNELS-1][DEST_WIDTH-1:0]  upstream destination
- is_tail_in  in  [0:NUM_CHANNELS-1]  last flit of packet
- send_in  in  [0:NUM_CHANNELS-1]  flit valid from upstream
- credit_out  out  [0:NUM_CHANNELS-1]  credit returned to upstream
- data_out / dest_out / is_tail_out / send_out  out  same widths  flit toward downstream
- credit_in  in  [0:NUM_CHANNELS-1]  credit from downstream
- credits_avail  out  [0:NUM_CHANNELS-1][CNT_WIDTH-1:0]  monitor's view of upstream credits
- err_underflow / err_overflow / err_dest  out  [0:NUM_CHANNELS-1]  sticky protocol errors
- err_clear  in  1  clears all sticky flags (and perf counters when enabled)
- perf_flits / perf_pkts  out  [0:NUM_CHANNELS-1][31:0]  performance counters

Behaviour:
- Forward path: latency exactly NUM_PIPELINE cycles.
  - send/is_tail stages reset to 0; data/dest stages reset to 0.
  - No backpressure. The link never drops or stalls a flit.
- Backward path: credit_in reaches credit_out after exactly NUM_PIPELINE cycles; credit stages reset to 0.
- NUM_PIPELINE=0: outputs are pure wires of inputs; the monitor is still active.
- Credit monitor (per channel, observes send_in and credit_out):
  - Reset value: FLIT_BUFFER_DEPTH.
  - send_in only: decrement. credit_out only: increment. Both together: unchanged.
  - send_in with count 0 and no credit_out: err_underflow set, count holds 0.
  - credit_out with count FLIT_BUFFER_DEPTH and no send_in: err_overflow set, count holds.
  - credits_avail = registered count.
- Packet FSM per channel, states IDLE and BODY; reset to IDLE:
  - IDLE: send_in & !is_tail_in -> BODY, latch dest_in.
  - IDLE: send_in & is_tail_in -> IDLE (single-flit packet).
  - BODY: send_in & dest_in != latched dest -> err_dest set.
  - BODY: send_in & is_tail_in -> IDLE.
  - BODY: no send -> stay in BODY.
- Sticky errors:
  - Reset to 0.
  - err_clear clears them the next cycle.
  - A new error in the same cycle as err_clear wins: the flag ends at 1.
- Reset mid-packet: all pipeline stages flush. In-flight flits and credits are discarded; FSM -> IDLE; counts -> FLIT_BUFFER_DEPTH. Reset of both routers is coordinated externally.
- All outputs are registered except in the NUM_PIPELINE=0 data path.

Optional Feature:
- Macro NOC_LINK_PERF_EN.
- Defined:
  - perf_flits increments on each send_in.
  - perf_pkts increments on each send_in & is_tail_in.
  - Both are 32-bit, saturate at all-ones, reset to 0, and are cleared by err_clear; an increment in the same cycle as err_clear yields 1.
- Undefined: perf_flits/perf_pkts are tied to 0 and no counter flops are built. Ports remain for interface stability.

Decomposition:
- Shared package noc_link_pkg holds:
  - typedef link_state_e {LINK_IDLE, LINK_BODY}
  - struct flit_t {data, dest, is_tail, send}, parametrised via the package's FLIT_WIDTH/DEST_WIDTH defaults
  - localparam PERF_CNT_WIDTH = 32
- One sub-module, noc_link_monitor, holds one channel's credit counter, FSM, sticky errors and perf counters. It is instantiated NUM_CHANNELS times in a generate loop. The pipeline stages are inline shift registers.

Test Plan:
- NUM_PIPELINE=2; send 3-flit packet on ch1 (dest 6'h05, tail on flit 3) -> send_out[1] high cycles t+2..t+4, same data/dest, tail on 3rd; no errors.
- FLIT_BUFFER_DEPTH=4; 4 sends, no credits -> credits_avail 0. 5th send -> err_underflow[ch]=1, count stays 0.
- Simultaneous send_in and returning credit_out at count 2 -> count stays 2. Credit at count 4 with no send -> err_overflow=1.
- Multi-flit packet whose 2nd flit has dest 6'h03 vs header 6'h05 -> err_dest=1. err_clear pulse -> 0 next cycle. err_clear coincident with new violation -> stays 1.
- rst_n low mid-packet with flits in flight (NUM_PIPELINE=3) -> next cycle after release all send_out/credit_out 0, credits_avail=FLIT_BUFFER_DEPTH, FSM IDLE.
- With NOC_LINK_PERF_EN: 10 packets of 3 flits -> perf_flits=30, perf_pkts=10. Without the macro both read 0.
